// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: walks the shift amount one power-of-two stage per clock
// through a single shared stage datapath (SLL / SRA / SRL).
module shift_sequencer #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in_data,
    input  logic [4:0]  shamt,
    input  logic        cancel,
    output logic        busy,
    output logic        result_ready,
    output logic [31:0] result,
    output logic        op_error
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned KW = 3;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   acc, acc_n;
    logic [SW-1:0]   shamt_q, shamt_n;
    logic [1:0]      op_q, op_n;
    logic [KW-1:0]   k, k_n;
    logic            err_n;
    logic [SW-1:0]   stage_amt;
    logic [SW-1:0]   lower_bits;
    logic [DW-1:0]   stage_out;

    // Index of the highest set bit; callers guarantee v is nonzero.
    function automatic logic [KW-1:0] msb_idx(input logic [SW-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < int'(SW); i++) begin
            if (v[i]) msb_idx = KW'(i);
        end
    endfunction

    // Shared stage datapath: shift the accumulator by 2^k.
    always_comb begin
        stage_amt  = SW'(5'd1 << k);
        lower_bits = shamt_q & (stage_amt - SW'(1));
        case (op_q)
            OP_SLL:  stage_out = acc << stage_amt;
            OP_SRA:  stage_out = DW'($signed(acc) >>> stage_amt);
            OP_SRL:  stage_out = acc >> stage_amt;
            default: stage_out = acc;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        shamt_n = shamt_q;
        op_n    = op_q;
        k_n     = k;
        err_n   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    acc_n   = in_data;
                    shamt_n = shamt;
                    op_n    = op;
                    if (op == OP_BAD || shamt == '0) begin
                        state_n = DONE;
                        err_n   = (op == OP_BAD);
                    end else begin
                        state_n = SHIFT;
                        k_n     = SKIP_ZERO ? msb_idx(shamt) : KW'(4);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cancel) begin
                    state_n = IDLE;
                end else begin
                    if (shamt_q[k]) acc_n = stage_out;
                    if (SKIP_ZERO ? (lower_bits == '0) : (k == '0)) begin
                        state_n = DONE;
                    end else begin
                        k_n = SKIP_ZERO ? msb_idx(lower_bits) : (k - KW'(1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; result only updates when an operation completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            acc          <= '0;
            shamt_q      <= '0;
            op_q         <= '0;
            k            <= KW'(4);
            busy         <= 1'b0;
            result_ready <= 1'b0;
            op_error     <= 1'b0;
            result       <= '0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            shamt_q      <= shamt_n;
            op_q         <= op_n;
            k            <= k_n;
            busy         <= (state_n == SHIFT);
            result_ready <= (state_n == DONE);
            op_error     <= err_n;
            if (state_n == DONE) result <= acc_n;
        end
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle 32-bit shift controller for the ALU shift path. It accepts one shift request at a time and decomposes the 5-bit shift amount into power-of-two stages (16, 8, 4, 2, 1). It applies one stage per clock to an internal accumulator through a single shared stage datapath. Three operations are supported: logical left, arithmetic right and logical right. It replaces the fully combinational barrel path where timing requires it.

Parameters:
SKIP_ZERO, 0, 1 = stages whose shamt bit is 0 consume no cycle; 0 = all five stages always visited (fixed latency).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request strobe; sampled only when busy=0
op  input  2  00 SLL, 01 SRA, 10 SRL, 11 illegal
in_data  input  32  operand
shamt  input  5  shift amount 0..31
cancel  input  1  abort the in-flight operation
busy  output  1  high while in SHIFT state
result_ready  output  1  one-cycle pulse: result valid
result  output  32  shifted value; holds until the next accepted start
op_error  output  1  one-cycle pulse alongside result_ready when op=11

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy=0, result_ready=0, op_error=0, result=0, accumulator=0, stage index=4. Reset mid-operation discards the operation and produces no result_ready.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE with start=1:
  - Latch in_data into the accumulator; latch shamt and op.
  - op=11 or shamt=0: go to DONE. Accumulator = in_data unchanged; op_error=1 if op=11.
  - Otherwise go to SHIFT with k=4. If SKIP_ZERO=1, k = index of the highest set shamt bit.
- IDLE/DONE with start=0: IDLE stays IDLE. DONE goes to IDLE.
- SHIFT, each edge:
  - If shamt[k]=1, accumulator <= stage(accumulator, 2^k, op). Otherwise accumulator unchanged.
  - If k=0 (SKIP_ZERO=0), or no lower set bit remains (SKIP_ZERO=1): go to DONE. Otherwise k <= next stage (k-1, or the next lower set bit).
- Stage function:
  - SLL: zero-fill from the LSB end.
  - SRL: zero-fill from the MSB end.
  - SRA: fill with the accumulator's bit 31, which is the original sign because prior stages preserve it.
- DONE (one cycle): result_ready=1. result drives the accumulator. result stays stable after DONE until the next accepted start's result is written.
- Latency, from the start-sampling edge to the first cycle with result_ready=1:
  - shamt=0 or op=11: 1 cycle.
  - SKIP_ZERO=0, any nonzero shamt: 6 cycles (5 SHIFT + DONE).
  - SKIP_ZERO=1: popcount(shamt) + 1 cycles.
- Back-to-back: start is accepted in the DONE cycle. The next operation begins without an IDLE bubble. result_ready is still emitted for the finishing operation.
- start while busy=1: ignored, with no effect on the latched operands.
- cancel in SHIFT: next edge goes to IDLE. No result_ready. result retains its previous value. cancel in IDLE/DONE has no effect.
- cancel and start together in DONE: start wins.
- busy is asserted exactly in SHIFT state. busy and result_ready are never high together.

Test Plan:
1. SRA, in_data=0x80000000, shamt=4, SKIP_ZERO=0 -> result=0xF8000000; result_ready pulses exactly 6 cycles after start; busy high for 5 cycles.
2. SLL, in_data=0x00000001, shamt=31; SRL, in_data=0xF0000000, shamt=28 -> results 0x80000000 and 0x0000000F. With SKIP_ZERO=1, latencies are 6 and 4 cycles.
3. shamt=0, in_data=0x12345678, any legal op -> result=0x12345678 one cycle after start. op=11 -> result=in_data and op_error=1 coincident with result_ready.
4. Start SRA 0xFFFF0000 by 8; assert start with different operands at SHIFT cycle 2 -> second start ignored, result=0xFFFFFF00. New start in the DONE cycle is accepted and busy rises the next cycle.
5. Previous result 0xAAAAAAAA; start SRL 0xFFFFFFFF by 16; assert cancel in SHIFT cycle 3 -> IDLE next edge, no result_ready, result still 0xAAAAAAAA.
6. Drive reset low asynchronously mid-SHIFT (between edges) -> busy=0, result=0, result_ready=0 immediately. After release, a fresh SLL of 0x1 by 1 returns 0x00000002.
